// File: rtl/snes_hv_latch.sv
`default_nettype none
// ============================================================================
// Module   : snes_hv_latch
// Purpose  : PPU2 H/V counter latch. Captures the dot/line counters on a
//            light-gun pin-6 strobe or a $2137 read, and serves the CPU reads
//            of OPHCT ($213C), OPVCT ($213D) and STAT78 ($213F), including the
//            byte-select flip-flops and the latch flag.
// Options  : HVLATCH_SYNC_EN - when defined, EXT_LATCH_N is passed through a
//            2-FF synchronizer before falling-edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module snes_hv_latch #(
  parameter logic [3:0] PPU2_VER  = 4'd3,
  parameter int         LATCH_DLY = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DOT_CE,
  input  logic [8:0] HCNT,
  input  logic [8:0] VCNT,
  input  logic       FIELD,
  input  logic       PAL,
  input  logic       EXT_LATCH_N,
  input  logic       WRIO7,
  input  logic       SLHV_RD,
  input  logic       OPHCT_RD,
  input  logic       OPVCT_RD,
  input  logic       STAT78_RD,
  input  logic [7:0] OPEN_BUS,
  output logic [7:0] DOUT,
  output logic       LATCHED
);

  // Delay counter load value, truncated to the 3-bit counter range.
  localparam logic [2:0] C_DLY = 3'(LATCH_DLY);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [8:0] oph_q, oph_d;
  logic [8:0] opv_q, opv_d;
  logic       latched_q, latched_d;
  logic       hff_q, hff_d;
  logic       vff_q, vff_d;
  logic [7:0] dout_q, dout_d;

  logic       w_fall;
  logic       w_trigger;
  logic       w_capture;

  // OPEN_BUS[0] is never visible: bit 0 of every PPU2 byte read here is driven.
  logic       w_unused_bus;
  assign w_unused_bus = OPEN_BUS[0];

`ifdef HVLATCH_SYNC_EN
  logic sync1_q, sync2_q, prev_q;

  // Two-stage synchronizer plus one history stage for the edge detector.
  // Idle-high reset values keep a pin held high from looking like an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= EXT_LATCH_N;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_fall = prev_q & ~sync2_q;
`else
  logic ext_q;

  // Single history register; the pin is already synchronous to CLK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ext_q <= 1'b1;
    end else begin
      ext_q <= EXT_LATCH_N;
    end
  end

  assign w_fall = ext_q & ~EXT_LATCH_N;
`endif

  // Both latch sources are gated by $4201 bit 7.
  assign w_trigger = WRIO7 & (w_fall | SLHV_RD);

  // Capture fires on the dot enable that finds the delay counter exhausted,
  // unless WRIO7 has dropped, which cancels the pending capture.
  assign w_capture = (state_q == ST_WAIT) && WRIO7 && DOT_CE && (cnt_q == 3'd0);

  // State, delay counter and all latch/read registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      oph_q     <= 9'd0;
      opv_q     <= 9'd0;
      latched_q <= 1'b0;
      hff_q     <= 1'b0;
      vff_q     <= 1'b0;
      dout_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      oph_q     <= oph_d;
      opv_q     <= opv_d;
      latched_q <= latched_d;
      hff_q     <= hff_d;
      vff_q     <= vff_d;
      dout_q    <= dout_d;
    end
  end

  // Next-state logic for the trigger/delay FSM and the counter capture.
  // A trigger arriving while a capture is pending is simply dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oph_d   = oph_q;
    opv_d   = opv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_trigger) begin
          state_d = ST_WAIT;
          cnt_d   = C_DLY;
        end
      end
      ST_WAIT: begin
        if (!WRIO7) begin
          state_d = ST_IDLE;
        end else if (DOT_CE) begin
          if (cnt_q == 3'd0) begin
            state_d = ST_IDLE;
            oph_d   = HCNT;
            opv_d   = VCNT;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // CPU read path and flag/flip-flop updates. Reads always see the values
  // held before this cycle's capture; a capture in the same cycle as a
  // STAT78 read re-sets the flag after the read has cleared it.
  always_comb begin
    dout_d    = dout_q;
    latched_d = latched_q;
    hff_d     = hff_q;
    vff_d     = vff_q;
    if (STAT78_RD) begin
      dout_d    = {FIELD, latched_q, OPEN_BUS[5], PAL, PPU2_VER};
      latched_d = 1'b0;
      hff_d     = 1'b0;
      vff_d     = 1'b0;
    end else if (OPHCT_RD) begin
      dout_d = hff_q ? {OPEN_BUS[7:1], oph_q[8]} : oph_q[7:0];
      hff_d  = ~hff_q;
    end else if (OPVCT_RD) begin
      dout_d = vff_q ? {OPEN_BUS[7:1], opv_q[8]} : opv_q[7:0];
      vff_d  = ~vff_q;
    end
    if (w_capture) begin
      latched_d = 1'b1;
    end
  end

  assign DOUT    = dout_q;
  assign LATCHED = latched_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_hv_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_snes_hv_latch
// Purpose  : Directed self-checking bench for snes_hv_latch (default build,
//            PPU2_VER=3, LATCH_DLY=2, OPEN_BUS=0xA5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snes_hv_latch;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DOT_CE = 1'b0;
  logic [8:0] HCNT = 9'd0;
  logic [8:0] VCNT = 9'd0;
  logic       FIELD = 1'b0;
  logic       PAL = 1'b0;
  logic       EXT_LATCH_N = 1'b1;
  logic       WRIO7 = 1'b1;
  logic       SLHV_RD = 1'b0;
  logic       OPHCT_RD = 1'b0;
  logic       OPVCT_RD = 1'b0;
  logic       STAT78_RD = 1'b0;
  logic [7:0] OPEN_BUS = 8'hA5;
  logic [7:0] DOUT;
  logic       LATCHED;

  int n_pass  = 0;
  int n_total = 0;

  snes_hv_latch #(.PPU2_VER(4'd3), .LATCH_DLY(2)) dut (
    .CLK(CLK), .RESET(RESET), .DOT_CE(DOT_CE), .HCNT(HCNT), .VCNT(VCNT),
    .FIELD(FIELD), .PAL(PAL), .EXT_LATCH_N(EXT_LATCH_N), .WRIO7(WRIO7),
    .SLHV_RD(SLHV_RD), .OPHCT_RD(OPHCT_RD), .OPVCT_RD(OPVCT_RD),
    .STAT78_RD(STAT78_RD), .OPEN_BUS(OPEN_BUS), .DOUT(DOUT), .LATCHED(LATCHED)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic clk1;
    @(posedge CLK);
    #1;
  endtask

  task automatic dot(input logic [8:0] h, input logic [8:0] v);
    HCNT = h; VCNT = v; DOT_CE = 1'b1;
    clk1();
    DOT_CE = 1'b0;
  endtask

  task automatic pin_fall;
    EXT_LATCH_N = 1'b0;
    clk1();
  endtask

  task automatic pin_rise;
    EXT_LATCH_N = 1'b1;
    clk1();
  endtask

  task automatic rd_h;
    OPHCT_RD = 1'b1; clk1(); OPHCT_RD = 1'b0;
  endtask

  task automatic rd_v;
    OPVCT_RD = 1'b1; clk1(); OPVCT_RD = 1'b0;
  endtask

  task automatic rd_s;
    STAT78_RD = 1'b1; clk1(); STAT78_RD = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    clk1(); clk1(); clk1();
    RESET = 1'b0;
    clk1();
    n_total++;
    if (DOUT !== 8'h00) $display("FAIL reset_dout: DOUT=%h expected 00", DOUT);
    else n_pass++;
    n_total++;
    if (LATCHED !== 1'b0) $display("FAIL reset_latched: LATCHED=%b expected 0", LATCHED);
    else n_pass++;
  endtask

  task automatic test_ext_latch;
    WRIO7 = 1'b1;
    pin_fall();
    dot(9'd1, 9'd1);
    dot(9'd2, 9'd2);
    n_total++;
    if (LATCHED !== 1'b0) $display("FAIL ext_early: LATCHED=%b expected 0", LATCHED);
    else n_pass++;
    dot(9'd100, 9'd50);
    n_total++;
    if (LATCHED !== 1'b1) $display("FAIL ext_latched: LATCHED=%b expected 1", LATCHED);
    else n_pass++;
    pin_rise();
    rd_h();
    n_total++;
    if (DOUT !== 8'h64) $display("FAIL ext_oph_lo: DOUT=%h expected 64", DOUT);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'hA4) $display("FAIL ext_oph_hi: DOUT=%h expected a4", DOUT);
    else n_pass++;
    rd_v();
    n_total++;
    if (DOUT !== 8'h32) $display("FAIL ext_opv_lo: DOUT=%h expected 32", DOUT);
    else n_pass++;
    rd_s();
    n_total++;
    if (DOUT !== 8'h63) $display("FAIL ext_stat: DOUT=%h expected 63", DOUT);
    else n_pass++;
  endtask

  task automatic test_wrio7_off;
    WRIO7 = 1'b0;
    pin_fall();
    pin_rise();
    SLHV_RD = 1'b1; clk1(); SLHV_RD = 1'b0;
    for (int i = 0; i < 4; i++) dot(9'd200, 9'd150);
    n_total++;
    if (LATCHED !== 1'b0) $display("FAIL wrio_latched: LATCHED=%b expected 0", LATCHED);
    else n_pass++;
    WRIO7 = 1'b1;
    rd_h();
    n_total++;
    if (DOUT !== 8'h64) $display("FAIL wrio_oph: DOUT=%h expected 64", DOUT);
    else n_pass++;
    rd_v();
    n_total++;
    if (DOUT !== 8'h32) $display("FAIL wrio_opv: DOUT=%h expected 32", DOUT);
    else n_pass++;
  endtask

  task automatic test_hcnt300;
    FIELD = 1'b1; PAL = 1'b1;
    rd_s();
    n_total++;
    if (DOUT !== 8'hB3) $display("FAIL h300_stat0: DOUT=%h expected b3", DOUT);
    else n_pass++;
    SLHV_RD = 1'b1; clk1(); SLHV_RD = 1'b0;
    n_total++;
    if (DOUT !== 8'hB3) $display("FAIL h300_slhv_dout: DOUT=%h expected b3", DOUT);
    else n_pass++;
    for (int i = 0; i < 3; i++) dot(9'd300, 9'd10);
    n_total++;
    if (LATCHED !== 1'b1) $display("FAIL h300_latched: LATCHED=%b expected 1", LATCHED);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'h2C) $display("FAIL h300_pre: DOUT=%h expected 2c", DOUT);
    else n_pass++;
    rd_s();
    n_total++;
    if (DOUT !== 8'hF3) $display("FAIL h300_stat: DOUT=%h expected f3", DOUT);
    else n_pass++;
    n_total++;
    if (LATCHED !== 1'b0) $display("FAIL h300_clear: LATCHED=%b expected 0", LATCHED);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'h2C) $display("FAIL h300_lo: DOUT=%h expected 2c", DOUT);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'hA5) $display("FAIL h300_hi: DOUT=%h expected a5", DOUT);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    pin_fall();
    dot(9'd10, 9'd20);
    pin_rise();
    pin_fall();
    dot(9'd11, 9'd21);
    dot(9'd12, 9'd22);
    pin_rise();
    for (int i = 0; i < 4; i++) dot(9'd40, 9'd41);
    n_total++;
    if (LATCHED !== 1'b1) $display("FAIL b2b_latched: LATCHED=%b expected 1", LATCHED);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'h0C) $display("FAIL b2b_oph: DOUT=%h expected 0c", DOUT);
    else n_pass++;
    rd_v();
    n_total++;
    if (DOUT !== 8'h16) $display("FAIL b2b_opv: DOUT=%h expected 16", DOUT);
    else n_pass++;
  endtask

  task automatic test_same_cycle;
    rd_s();
    FIELD = 1'b0; PAL = 1'b0;
    pin_fall();
    pin_rise();
    dot(9'd1, 9'd1);
    dot(9'd2, 9'd2);
    STAT78_RD = 1'b1;
    dot(9'd77, 9'd88);
    STAT78_RD = 1'b0;
    n_total++;
    if (DOUT !== 8'h23) $display("FAIL cap_stat_dout: DOUT=%h expected 23", DOUT);
    else n_pass++;
    n_total++;
    if (LATCHED !== 1'b1) $display("FAIL cap_stat_flag: LATCHED=%b expected 1", LATCHED);
    else n_pass++;
    SLHV_RD = 1'b1; clk1(); SLHV_RD = 1'b0;
    dot(9'd1, 9'd1);
    dot(9'd2, 9'd2);
    OPHCT_RD = 1'b1;
    dot(9'h150, 9'h101);
    OPHCT_RD = 1'b0;
    n_total++;
    if (DOUT !== 8'h4D) $display("FAIL cap_oph_old: DOUT=%h expected 4d", DOUT);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'hA5) $display("FAIL cap_oph_new: DOUT=%h expected a5", DOUT);
    else n_pass++;
  endtask

  task automatic test_priority;
    STAT78_RD = 1'b1; OPHCT_RD = 1'b1; OPVCT_RD = 1'b1;
    clk1();
    STAT78_RD = 1'b0; OPHCT_RD = 1'b0; OPVCT_RD = 1'b0;
    n_total++;
    if (DOUT !== 8'h63) $display("FAIL prio_dout: DOUT=%h expected 63", DOUT);
    else n_pass++;
    OPHCT_RD = 1'b1; OPVCT_RD = 1'b1;
    clk1();
    OPHCT_RD = 1'b0; OPVCT_RD = 1'b0;
    n_total++;
    if (DOUT !== 8'h50) $display("FAIL prio_h_over_v: DOUT=%h expected 50", DOUT);
    else n_pass++;
    rd_v();
    n_total++;
    if (DOUT !== 8'h01) $display("FAIL prio_vff_kept: DOUT=%h expected 01", DOUT);
    else n_pass++;
  endtask

  task automatic test_cancel;
    rd_s();
    pin_fall();
    dot(9'd5, 9'd5);
    WRIO7 = 1'b0;
    clk1();
    WRIO7 = 1'b1;
    pin_rise();
    for (int i = 0; i < 4; i++) dot(9'd6, 9'd6);
    n_total++;
    if (LATCHED !== 1'b0) $display("FAIL cancel_flag: LATCHED=%b expected 0", LATCHED);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'h50) $display("FAIL cancel_oph: DOUT=%h expected 50", DOUT);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait;
    pin_fall();
    dot(9'd99, 9'd99);
    RESET = 1'b1;
    clk1();
    RESET = 1'b0;
    pin_rise();
    n_total++;
    if (DOUT !== 8'h00) $display("FAIL rstw_dout: DOUT=%h expected 00", DOUT);
    else n_pass++;
    for (int i = 0; i < 4; i++) dot(9'd99, 9'd99);
    n_total++;
    if (LATCHED !== 1'b0) $display("FAIL rstw_flag: LATCHED=%b expected 0", LATCHED);
    else n_pass++;
    rd_h();
    n_total++;
    if (DOUT !== 8'h00) $display("FAIL rstw_oph: DOUT=%h expected 00", DOUT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ext_latch();
    test_wrio7_off();
    test_hcnt300();
    test_back_to_back();
    test_same_cycle();
    test_priority();
    test_cancel();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
